flow_table_release: RTL and testbench

Frees queue entries of the flow map-table once a reassembled packet has left its reassembly queue. It is the release side of the same 32-entry flow map-table RAM that the flow lookup engine allocates into. For each release request it reads the entry, checks that the entry is valid and owned by the flow, and then invalidates it. It shares the table's read and write ports with the lookup engine through a busy/hold-off handshake, and reports per-release status and counters.

---
 rtl/flow_table_release_if.sv | 45 ++++
 rtl/flow_table_release.sv | 178 +++++++++++++++++
 tb/tb_flow_table_release.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flow_table_release_if.sv
// Signal bundle between the flow map-table release engine and its environment
// (request source, lookup engine arbitration, shared table RAM ports, status).
`timescale 1ns/1ps
interface flow_table_release_if;
    logic        i_free_req;
    logic [4:0]  iv_free_queue_id;
    logic [13:0] iv_free_flowid;
    logic        o_free_full;
    logic        i_lookup_busy;
    logic        i_flowid_wr;
    logic        o_release_busy;
    logic        o_fmt_ram_rd;
    logic [4:0]  ov_fmt_ram_raddr;
    logic [18:0] iv_fmt_ram_rdata;
    logic        o_free_ram_wr;
    logic [4:0]  ov_free_ram_waddr;
    logic [18:0] ov_free_ram_wdata;
    logic        o_free_done;
    logic        o_free_mismatch;
    logic [4:0]  ov_free_done_queue_id;
    logic [3:0]  ov_free_usedw;
    logic [15:0] ov_free_cnt;
    logic [15:0] ov_mismatch_cnt;
    logic [15:0] ov_drop_cnt;

    // The release engine side.
    modport master (
        input  i_free_req, iv_free_queue_id, iv_free_flowid,
        input  i_lookup_busy, i_flowid_wr, iv_fmt_ram_rdata,
        output o_free_full, o_release_busy, o_fmt_ram_rd, ov_fmt_ram_raddr,
        output o_free_ram_wr, ov_free_ram_waddr, ov_free_ram_wdata,
        output o_free_done, o_free_mismatch, ov_free_done_queue_id, ov_free_usedw,
        output ov_free_cnt, ov_mismatch_cnt, ov_drop_cnt
    );

    // The environment: request source, lookup engine and table RAM.
    modport slave (
        output i_free_req, iv_free_queue_id, iv_free_flowid,
        output i_lookup_busy, i_flowid_wr, iv_fmt_ram_rdata,
        input  o_free_full, o_release_busy, o_fmt_ram_rd, ov_fmt_ram_raddr,
        input  o_free_ram_wr, ov_free_ram_waddr, ov_free_ram_wdata,
        input  o_free_done, o_free_mismatch, ov_free_done_queue_id, ov_free_usedw,
        input  ov_free_cnt, ov_mismatch_cnt, ov_drop_cnt
    );
endinterface

// File: rtl/flow_table_release.sv
// Release engine of the 32-entry flow map-table: reads an entry, checks it is valid
// and owned by the requesting flow, then invalidates it, sharing the RAM with lookup.
`timescale 1ns/1ps
module flow_table_release #(
    parameter int RAM_RD_LAT = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    flow_table_release_if.master tbl
);
    localparam int WAIT_W = (RAM_RD_LAT > 1) ? $clog2(RAM_RD_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_S  = 2'd1,
        CHECK_S = 2'd2,
        WRITE_S = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    state_t             state;
    logic [4:0]         fifo_qid [2];
    logic [13:0]        fifo_flowid [2];
    logic [1:0]         fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               drop;
    logic               start;

    logic [4:0]         work_qid;
    logic [13:0]        work_flowid;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               hit;

    logic               release_busy;
    logic               ram_rd;
    logic [4:0]         ram_raddr;
    logic               ram_wr;
    logic [4:0]         ram_waddr;
    logic               free_done;
    logic               free_mismatch;
    logic [4:0]         done_queue_id;
    logic [3:0]         free_usedw;
    logic [15:0]        free_cnt;
    logic [15:0]        mismatch_cnt;
    logic [15:0]        drop_cnt;

    // Fullness is judged on the occupancy at the start of the cycle, so a push
    // into a full FIFO is dropped even if the same cycle pops the head.
    assign fifo_full  = (fifo_count == 2'd2);
    assign fifo_empty = (fifo_count == 2'd0);
    assign push       = tbl.i_free_req && !fifo_full;
    assign drop       = tbl.i_free_req && fifo_full;
    assign start      = (state == IDLE) && !fifo_empty && !tbl.i_lookup_busy && !tbl.i_flowid_wr;

    assign hit = tbl.iv_fmt_ram_rdata[18] && (tbl.iv_fmt_ram_rdata[17:4] == work_flowid);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fifo_count <= 2'd0;
        end else begin
            case ({push, start})
                2'b10: begin
                    fifo_qid[fifo_count[0]]    <= tbl.iv_free_queue_id;
                    fifo_flowid[fifo_count[0]] <= tbl.iv_free_flowid;
                    fifo_count                 <= fifo_count + 2'd1;
                end
                2'b01: begin
                    fifo_qid[0]    <= fifo_qid[1];
                    fifo_flowid[0] <= fifo_flowid[1];
                    fifo_count     <= fifo_count - 2'd1;
                end
                // Push and pop together only happen with one entry held.
                2'b11: begin
                    fifo_qid[0]    <= tbl.iv_free_queue_id;
                    fifo_flowid[0] <= tbl.iv_free_flowid;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_cnt <= 16'd0;
        end else if (drop) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            work_qid      <= 5'd0;
            work_flowid   <= 14'd0;
            wait_cnt      <= '0;
            release_busy  <= 1'b0;
            ram_rd        <= 1'b0;
            ram_raddr     <= 5'd0;
            ram_wr        <= 1'b0;
            ram_waddr     <= 5'd0;
            free_done     <= 1'b0;
            free_mismatch <= 1'b0;
            done_queue_id <= 5'd0;
            free_usedw    <= 4'd0;
            free_cnt      <= 16'd0;
            mismatch_cnt  <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    ram_rd <= 1'b0;
                    if (start) begin
                        work_qid     <= fifo_qid[0];
                        work_flowid  <= fifo_flowid[0];
                        ram_rd       <= 1'b1;
                        ram_raddr    <= fifo_qid[0];
                        release_busy <= 1'b1;
                        wait_cnt     <= WAIT_W'(RAM_RD_LAT - 1);
                        state        <= WAIT_S;
                    end
                end
                // The counter covers the RAM latency so CHECK_S lands on valid data.
                WAIT_S: begin
                    ram_rd <= 1'b0;
                    if (wait_cnt == '0) begin
                        state <= CHECK_S;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                CHECK_S: begin
                    done_queue_id <= work_qid;
                    free_usedw    <= tbl.iv_fmt_ram_rdata[3:0];
                    if (hit) begin
                        ram_wr    <= 1'b1;
                        ram_waddr <= work_qid;
                        free_done <= 1'b1;
                        free_cnt  <= sat_inc(free_cnt);
                    end else begin
                        free_mismatch <= 1'b1;
                        mismatch_cnt  <= sat_inc(mismatch_cnt);
                    end
                    state <= WRITE_S;
                end
                WRITE_S: begin
                    ram_wr        <= 1'b0;
                    free_done     <= 1'b0;
                    free_mismatch <= 1'b0;
                    release_busy  <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign tbl.o_free_full           = fifo_full;
    assign tbl.o_release_busy        = release_busy;
    assign tbl.o_fmt_ram_rd          = ram_rd;
    assign tbl.ov_fmt_ram_raddr      = ram_raddr;
    assign tbl.o_free_ram_wr         = ram_wr;
    assign tbl.ov_free_ram_waddr     = ram_waddr;
    assign tbl.ov_free_ram_wdata     = 19'd0;
    assign tbl.o_free_done           = free_done;
    assign tbl.o_free_mismatch       = free_mismatch;
    assign tbl.ov_free_done_queue_id = done_queue_id;
    assign tbl.ov_free_usedw         = free_usedw;
    assign tbl.ov_free_cnt           = free_cnt;
    assign tbl.ov_mismatch_cnt       = mismatch_cnt;
    assign tbl.ov_drop_cnt           = drop_cnt;
endmodule

// File: tb/tb_flow_table_release.sv
// Bench for flow_table_release: a table RAM model, a scoreboard of expected release
// outcomes, table-driven release vectors and hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_flow_table_release;
    localparam int RAM_RD_LAT = 2;

    typedef struct {
        logic        load;
        logic [4:0]  qid;
        logic [18:0] entry;
        logic [13:0] flowid;
        logic        match;
        logic [3:0]  usedw;
    } vec_t;

    typedef struct {
        logic [4:0] qid;
        logic [3:0] usedw;
        logic       match;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          exp_free = 0;
    int          exp_mis = 0;
    int          exp_drop = 0;
    exp_t        exp_q[$];
    vec_t        vecs[8];

    logic [18:0] mem [32];
    logic [18:0] rd_pipe;
    logic        pl_we;
    logic [4:0]  pl_addr;
    logic [18:0] pl_data;
    logic        prev_busy = 1'b0;
    logic        prev_wr = 1'b0;

    flow_table_release_if tbl ();

    flow_table_release #(.RAM_RD_LAT(RAM_RD_LAT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .tbl   (tbl.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Table RAM: data reaches the engine two cycles after the registered read strobe.
    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (tbl.o_free_ram_wr) begin
            mem[tbl.ov_free_ram_waddr] <= tbl.ov_free_ram_wdata;
        end
        if (tbl.o_fmt_ram_rd) begin
            rd_pipe <= mem[tbl.ov_fmt_ram_raddr];
        end
        tbl.iv_fmt_ram_rdata <= rd_pipe;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic score_pulse();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_pulse: done=%0b mismatch=%0b qid=%0d with nothing pending (cycle %0d)",
                     tbl.o_free_done, tbl.o_free_mismatch, tbl.ov_free_done_queue_id, cyc);
        end else begin
            e = exp_q.pop_front();
            check_output("sb_queue_id", tbl.ov_free_done_queue_id, e.qid);
            check_output("sb_usedw", tbl.ov_free_usedw, e.usedw);
            check_output("sb_done", tbl.o_free_done, e.match);
            check_output("sb_mismatch", tbl.o_free_mismatch, !e.match);
            check_output("sb_wr", tbl.o_free_ram_wr, e.match);
            if (e.match) begin
                check_output("sb_waddr", tbl.ov_free_ram_waddr, e.qid);
                check_output("sb_wdata", tbl.ov_free_ram_wdata, 0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (tbl.o_fmt_ram_rd) begin
                check_output("read_while_lookup", {prev_busy, prev_wr}, 0);
            end
            if (tbl.o_free_done || tbl.o_free_mismatch) begin
                score_pulse();
            end else begin
                check_output("stray_write", tbl.o_free_ram_wr, 0);
            end
        end
        prev_busy <= tbl.i_lookup_busy;
        prev_wr   <= tbl.i_flowid_wr;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] addr, input logic [18:0] data);
        pl_we   = 1'b1;
        pl_addr = addr;
        pl_data = data;
        step();
        pl_we = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [4:0] qid, input logic [13:0] fid, input logic expect_out,
                                  input logic match, input logic [3:0] usedw);
        exp_t e;
        if (expect_out) begin
            e.qid   = qid;
            e.usedw = usedw;
            e.match = match;
            exp_q.push_back(e);
            if (match) exp_free = (exp_free < 65535) ? exp_free + 1 : 65535;
            else       exp_mis  = (exp_mis < 65535) ? exp_mis + 1 : 65535;
        end
        tbl.i_free_req       = 1'b1;
        tbl.iv_free_queue_id = qid;
        tbl.iv_free_flowid   = fid;
        step();
        tbl.i_free_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || tbl.o_release_busy) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: %0d releases still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish by itself");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int first_rd;
        int second_rd;

        vecs[0] = '{1'b1, 5'd7,  {1'b1, 14'h0AAA, 4'd1},  14'h0BBB, 1'b0, 4'd1};
        vecs[1] = '{1'b1, 5'd8,  {1'b0, 14'h0123, 4'd9},  14'h0123, 1'b0, 4'd9};
        vecs[2] = '{1'b1, 5'd31, {1'b1, 14'h3FFF, 4'hF},  14'h3FFF, 1'b1, 4'hF};
        vecs[3] = '{1'b1, 5'd0,  {1'b1, 14'h0000, 4'd0},  14'h0000, 1'b1, 4'd0};
        vecs[4] = '{1'b1, 5'd12, {1'b1, 14'h2001, 4'd6},  14'h0001, 1'b0, 4'd6};
        vecs[5] = '{1'b0, 5'd5,  19'd0,                   14'h0123, 1'b0, 4'd0};
        vecs[6] = '{1'b1, 5'd20, {1'b1, 14'h1555, 4'hA},  14'h1554, 1'b0, 4'hA};
        vecs[7] = '{1'b0, 5'd31, 19'd0,                   14'h3FFF, 1'b0, 4'd0};

        rst                  = 1'b1;
        pl_we                = 1'b0;
        pl_addr              = 5'd0;
        pl_data              = 19'd0;
        tbl.i_free_req       = 1'b0;
        tbl.iv_free_queue_id = 5'd0;
        tbl.iv_free_flowid   = 14'd0;
        tbl.i_lookup_busy    = 1'b0;
        tbl.i_flowid_wr      = 1'b0;
        step();
        for (int i = 0; i < 32; i++) preload(5'(i), 19'd0);

        check_output("rst_full", tbl.o_free_full, 0);
        check_output("rst_busy", tbl.o_release_busy, 0);
        check_output("rst_rd", tbl.o_fmt_ram_rd, 0);
        check_output("rst_raddr", tbl.ov_fmt_ram_raddr, 0);
        check_output("rst_wr", tbl.o_free_ram_wr, 0);
        check_output("rst_waddr", tbl.ov_free_ram_waddr, 0);
        check_output("rst_done", tbl.o_free_done, 0);
        check_output("rst_mismatch", tbl.o_free_mismatch, 0);
        check_output("rst_done_qid", tbl.ov_free_done_queue_id, 0);
        check_output("rst_usedw", tbl.ov_free_usedw, 0);
        check_output("rst_free_cnt", tbl.ov_free_cnt, 0);
        check_output("rst_mismatch_cnt", tbl.ov_mismatch_cnt, 0);
        check_output("rst_drop_cnt", tbl.ov_drop_cnt, 0);
        rst = 1'b0;
        step();

        // Basic release with cycle-exact timing; T is the cycle after the request.
        preload(5'd5, {1'b1, 14'h0123, 4'd3});
        apply_stimulus(5'd5, 14'h0123, 1'b1, 1'b1, 4'd3);
        check_output("basic_rd_at_T", tbl.o_fmt_ram_rd, 0);
        check_output("basic_busy_at_T", tbl.o_release_busy, 0);
        step();
        check_output("basic_rd_T1", tbl.o_fmt_ram_rd, 1);
        check_output("basic_raddr_T1", tbl.ov_fmt_ram_raddr, 5);
        check_output("basic_busy_T1", tbl.o_release_busy, 1);
        step();
        check_output("basic_rd_T2", tbl.o_fmt_ram_rd, 0);
        check_output("basic_busy_T2", tbl.o_release_busy, 1);
        step();
        check_output("basic_wr_T3", tbl.o_free_ram_wr, 0);
        step();
        check_output("basic_wr_T4", tbl.o_free_ram_wr, 1);
        check_output("basic_done_T4", tbl.o_free_done, 1);
        check_output("basic_busy_T4", tbl.o_release_busy, 1);
        step();
        check_output("basic_wr_T5", tbl.o_free_ram_wr, 0);
        check_output("basic_busy_T5", tbl.o_release_busy, 0);
        check_output("basic_free_cnt", tbl.ov_free_cnt, 1);
        wait_idle("basic");

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].load) preload(vecs[i].qid, vecs[i].entry);
            apply_stimulus(vecs[i].qid, vecs[i].flowid, 1'b1, vecs[i].match, vecs[i].usedw);
            wait_idle("vec");
            check_output("vec_free_cnt", tbl.ov_free_cnt, exp_free);
            check_output("vec_mismatch_cnt", tbl.ov_mismatch_cnt, exp_mis);
        end

        // Lookup busy holds the release off; the read follows its drop by one cycle.
        preload(5'd9, {1'b1, 14'h0077, 4'd2});
        tbl.i_lookup_busy = 1'b1;
        apply_stimulus(5'd9, 14'h0077, 1'b1, 1'b1, 4'd2);
        for (int i = 0; i < 10; i++) begin
            check_output("arb_hold_rd", tbl.o_fmt_ram_rd, 0);
            step();
        end
        check_output("arb_hold_busy", tbl.o_release_busy, 0);
        tbl.i_lookup_busy = 1'b0;
        step();
        check_output("arb_release_rd", tbl.o_fmt_ram_rd, 1);
        check_output("arb_release_raddr", tbl.ov_fmt_ram_raddr, 9);
        wait_idle("arb");

        // A lookup start strobe in the would-be start cycle defers the release.
        preload(5'd10, {1'b1, 14'h0155, 4'd5});
        apply_stimulus(5'd10, 14'h0155, 1'b1, 1'b1, 4'd5);
        tbl.i_flowid_wr = 1'b1;
        step();
        check_output("flowid_wr_defer_rd", tbl.o_fmt_ram_rd, 0);
        tbl.i_flowid_wr = 1'b0;
        step();
        check_output("flowid_wr_start_rd", tbl.o_fmt_ram_rd, 1);
        wait_idle("flowid_wr");

        // FIFO fills to two, the third request is dropped, then both drain 5 cycles apart.
        preload(5'd11, {1'b1, 14'h0011, 4'd7});
        preload(5'd12, {1'b1, 14'h0012, 4'd8});
        tbl.i_lookup_busy = 1'b1;
        apply_stimulus(5'd11, 14'h0011, 1'b1, 1'b1, 4'd7);
        check_output("fifo_full_after1", tbl.o_free_full, 0);
        apply_stimulus(5'd12, 14'h0012, 1'b1, 1'b1, 4'd8);
        check_output("fifo_full_after2", tbl.o_free_full, 1);
        apply_stimulus(5'd13, 14'h0013, 1'b0, 1'b0, 4'd0);
        exp_drop++;
        check_output("fifo_drop_cnt", tbl.ov_drop_cnt, exp_drop);
        check_output("fifo_full_after3", tbl.o_free_full, 1);
        tbl.i_lookup_busy = 1'b0;
        first_rd  = -1;
        second_rd = -1;
        step();
        if (tbl.o_fmt_ram_rd) first_rd = 1;
        check_output("fifo_full_drain", tbl.o_free_full, 0);
        for (int i = 2; i <= 12; i++) begin
            step();
            if (tbl.o_fmt_ram_rd) begin
                if (first_rd < 0) first_rd = i;
                else if (second_rd < 0) second_rd = i;
            end
        end
        check_output("fifo_first_rd", first_rd, 1);
        check_output("fifo_rd_spacing", second_rd - first_rd, 5);
        wait_idle("fifo");
        check_output("fifo_free_cnt", tbl.ov_free_cnt, exp_free);
        check_output("fifo_drop_cnt_final", tbl.ov_drop_cnt, exp_drop);

        // Reset two cycles into a release, with a second request still queued.
        preload(5'd3, {1'b1, 14'h0333, 4'd4});
        apply_stimulus(5'd3, 14'h0333, 1'b0, 1'b0, 4'd0);
        apply_stimulus(5'd4, 14'h0444, 1'b0, 1'b0, 4'd0);
        check_output("rst_mid_rd", tbl.o_fmt_ram_rd, 1);
        step();
        rst = 1'b1;
        step();
        rst      = 1'b0;
        exp_free = 0;
        exp_mis  = 0;
        exp_drop = 0;
        for (int i = 0; i < 8; i++) begin
            check_output("rst_mid_wr", tbl.o_free_ram_wr, 0);
            check_output("rst_mid_done", tbl.o_free_done, 0);
            check_output("rst_mid_mismatch", tbl.o_free_mismatch, 0);
            check_output("rst_mid_no_read", tbl.o_fmt_ram_rd, 0);
            check_output("rst_mid_busy", tbl.o_release_busy, 0);
            step();
        end
        check_output("rst_mid_free_cnt", tbl.ov_free_cnt, 0);
        check_output("rst_mid_mismatch_cnt", tbl.ov_mismatch_cnt, 0);
        check_output("rst_mid_drop_cnt", tbl.ov_drop_cnt, 0);
        check_output("rst_mid_full", tbl.o_free_full, 0);
        check_output("rst_mid_done_qid", tbl.ov_free_done_queue_id, 0);
        check_output("rst_mid_usedw", tbl.ov_free_usedw, 0);
        apply_stimulus(5'd3, 14'h0333, 1'b1, 1'b1, 4'd4);
        wait_idle("rst_entry_intact");
        check_output("rst_after_free_cnt", tbl.ov_free_cnt, exp_free);

        // Saturation: start the counter just below its ceiling.
        force dut.free_cnt = 16'hFFFD;
        step();
        release dut.free_cnt;
        exp_free = 32'hFFFD;
        check_output("sat_preset", tbl.ov_free_cnt, exp_free);
        for (int k = 0; k < 3; k++) begin
            preload(5'd1, {1'b1, 14'h0001, 4'(k)});
            apply_stimulus(5'd1, 14'h0001, 1'b1, 1'b1, 4'(k));
            wait_idle("sat");
            check_output("sat_free_cnt", tbl.ov_free_cnt, exp_free);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
